tick_pulse_sequencer: RTL

Burst pulse generator that consumes the single-cycle `tick` produced by the clock-divider stage and turns it into programmable pulse trains on a 16-bit signed DAC output. It sits between the divider and `OutputA`/`OutputB` inside `CustomWrapper`. It takes its configuration from `Control` registers and its trigger from software or `ExtTrig`.

---
 rtl/tick_seq_pkg.sv | 15 +
 rtl/trig_sync.sv | 26 ++
 rtl/tick_pulse_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tick_seq_pkg.sv
// Shared types and constants for the tick-driven burst pulse sequencer.
package tick_seq_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_ONE    = 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/trig_sync.sv
// Brings the asynchronous external trigger into the clock domain and emits a
// registered one-cycle pulse on each rising edge.
module trig_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic ext_trig,
  output logic rise
);

  logic sync1, sync2, sync3;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= ext_trig;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/tick_pulse_sequencer.sv
// Turns divider ticks into programmable high/low pulse bursts on a signed DAC
// level, with software or external triggering and a done strobe per burst.
module tick_pulse_sequencer
  import tick_seq_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     tick,
  input  logic                     arm,
  input  logic                     sw_trig,
  input  logic                     ext_trig,
  input  logic [CNT_W-1:0]         high_ticks,
  input  logic [CNT_W-1:0]         low_ticks,
  input  logic [CNT_W-1:0]         pulse_count,
  input  logic signed [DATA_W-1:0] level_hi,
  input  logic signed [DATA_W-1:0] level_lo,
  output logic signed [DATA_W-1:0] out_level,
  output logic                     pulse_out,
  output logic                     busy,
  output logic                     done
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(CNT_ONE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                   state;
  logic [CNT_W-1:0]         phase_cnt, pulse_cnt, pulse_next;
  logic [CNT_W-1:0]         hi_len, lo_len, cnt_lat, hi_eff, lo_eff;
  logic signed [DATA_W-1:0] hi_lat, lo_lat;
  logic                     ext_rise, trig, phase_end;

  trig_sync u_trig_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .ext_trig (ext_trig),
    .rise     (ext_rise)
  );

  assign trig       = sw_trig | ext_rise;
  assign hi_eff     = (high_ticks == '0) ? ONE : high_ticks;
  assign lo_eff     = (low_ticks == '0) ? ONE : low_ticks;
  assign phase_end  = tick && (phase_cnt == ONE);
  // Saturate so a very long finite burst can never wrap back to a match.
  assign pulse_next = (pulse_cnt == CNT_MAX) ? pulse_cnt : pulse_cnt + ONE;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      hi_len    <= '0;
      lo_len    <= '0;
      cnt_lat   <= '0;
      hi_lat    <= '0;
      lo_lat    <= '0;
      out_level <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Dropping arm wins over any trigger or phase end in the same cycle.
      if (!arm) begin
        state     <= IDLE;
        pulse_out <= 1'b0;
        busy      <= 1'b0;
        out_level <= level_lo;
      end else begin
        unique case (state)
          IDLE: begin
            state     <= ARMED;
            out_level <= level_lo;
          end
          ARMED: begin
            if (trig) begin
              hi_len    <= hi_eff;
              lo_len    <= lo_eff;
              phase_cnt <= hi_eff;
              pulse_cnt <= '0;
              cnt_lat   <= pulse_count;
              hi_lat    <= level_hi;
              lo_lat    <= level_lo;
              state     <= HIGH;
              pulse_out <= 1'b1;
              busy      <= 1'b1;
              out_level <= level_hi;
            end else begin
              out_level <= level_lo;
            end
          end
          HIGH: begin
            if (phase_end) begin
              phase_cnt <= lo_len;
              state     <= LOW;
              pulse_out <= 1'b0;
              out_level <= lo_lat;
            end else if (tick) begin
              phase_cnt <= phase_cnt - ONE;
            end
          end
          LOW: begin
            if (phase_end) begin
              pulse_cnt <= pulse_next;
              if (cnt_lat != '0 && pulse_next == cnt_lat) begin
                done      <= 1'b1;
                busy      <= 1'b0;
                state     <= ARMED;
                out_level <= level_lo;
              end else begin
                phase_cnt <= hi_len;
                state     <= HIGH;
                pulse_out <= 1'b1;
                out_level <= hi_lat;
              end
            end else if (tick) begin
              phase_cnt <= phase_cnt - ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
